// File: rtl/recovery_ctrl_if.sv
// rtl/recovery_ctrl_if.sv - signal bundle between checkpoint unit, ready table, fetch and recovery_ctrl
//
// Purpose: groups every non-clock/reset signal of recovery_ctrl.
//   slave  modport : seen by recovery_ctrl (inputs from checkpoint unit / fetch, outputs to pipeline)
//   master modport : seen by whatever drives the controller (testbench, upstream glue)
// Ports carried:
//   checkpoint_valid, snapshot (checkpoint_t), mispredict_target, redirect_ready  -> controller
//   flush, stall_rename, rdy_restore_valid/idx/mask, redirect_valid/pc,
//   recover_rob_tag                                                               <- controller
//   recover_count, recover_cycles                      <- controller, only with RECOVERY_PERF_EN
interface recovery_ctrl_if #(
  parameter int NUM_PREG  = 128,
  parameter int RESTORE_W = 32
);
  localparam int NUM_CHUNKS = NUM_PREG / RESTORE_W;
  localparam int CW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef struct packed {
    logic                valid;
    logic [31:0]         pc;
    logic [4:0]          rob_tag;
    logic [NUM_PREG-1:0] reset_reg_rdy_table;
  } checkpoint_t;

  logic                 checkpoint_valid;
  checkpoint_t          snapshot;
  logic [31:0]          mispredict_target;
  logic                 redirect_ready;

  logic                 flush;
  logic                 stall_rename;
  logic                 rdy_restore_valid;
  logic [CW-1:0]        rdy_restore_idx;
  logic [RESTORE_W-1:0] rdy_restore_mask;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
  logic [4:0]           recover_rob_tag;
`ifdef RECOVERY_PERF_EN
  logic [15:0]          recover_count;
  logic [15:0]          recover_cycles;
`endif

  modport slave (
    input  checkpoint_valid,
    input  snapshot,
    input  mispredict_target,
    input  redirect_ready,
    output flush,
    output stall_rename,
    output rdy_restore_valid,
    output rdy_restore_idx,
    output rdy_restore_mask,
    output redirect_valid,
    output redirect_pc,
`ifdef RECOVERY_PERF_EN
    output recover_count,
    output recover_cycles,
`endif
    output recover_rob_tag
  );

  modport master (
    output checkpoint_valid,
    output snapshot,
    output mispredict_target,
    output redirect_ready,
    input  flush,
    input  stall_rename,
    input  rdy_restore_valid,
    input  rdy_restore_idx,
    input  rdy_restore_mask,
    input  redirect_valid,
    input  redirect_pc,
`ifdef RECOVERY_PERF_EN
    input  recover_count,
    input  recover_cycles,
`endif
    input  recover_rob_tag
  );
endinterface

// File: rtl/recovery_ctrl.sv
// rtl/recovery_ctrl.sv - branch-mispredict recovery sequencer (flush, ready-mask restore, fetch redirect)
//
// Purpose: on an accepted checkpoint snapshot, holds flush for FLUSH_CYCLES cycles, then streams
// the accumulated ready-restore mask to the ready table one RESTORE_W chunk per cycle (every chunk,
// zero or not), then requests a fetch redirect until fetch accepts it. Rename is stalled for the
// whole sequence. A new accept in any state restarts the sequence without losing mask bits.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   bus    - recovery_ctrl_if.slave (snapshot in, flush/restore/redirect/stall out)
// Optional feature macro: RECOVERY_PERF_EN adds recover_count / recover_cycles (saturating 16-bit).
// All outputs are decoded from registered state only.
module recovery_ctrl #(
  parameter int NUM_PREG     = 128,
  parameter int RESTORE_W    = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  recovery_ctrl_if.slave  bus
);
  localparam int NUM_CHUNKS = NUM_PREG / RESTORE_W;
  localparam int CW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int FCW        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [CW-1:0]  LAST_CHUNK = CW'(NUM_CHUNKS - 1);
  localparam logic [FCW-1:0] FLUSH_INIT = FCW'(FLUSH_CYCLES - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_RESTORE  = 2'd2;
  localparam logic [1:0] ST_REDIRECT = 2'd3;

  logic [1:0]          state_q,     state_d;
  logic [NUM_PREG-1:0] pending_q,   pending_d;
  logic [31:0]         target_q,    target_d;
  logic [4:0]          tag_q,       tag_d;
  logic [FCW-1:0]      flush_cnt_q, flush_cnt_d;
  logic [CW-1:0]       chunk_q,     chunk_d;
`ifdef RECOVERY_PERF_EN
  logic [15:0]         count_q,     count_d;
  logic [15:0]         cycles_q,    cycles_d;
`endif

  logic                accept;
  logic [RESTORE_W-1:0] cur_slice;
  int unsigned         slice_base;

  // The snapshot PC travels with the checkpoint but recovery redirects to mispredict_target.
  logic unused_snapshot_pc;
  assign unused_snapshot_pc = ^bus.snapshot.pc;

  assign accept     = bus.checkpoint_valid && bus.snapshot.valid;
  assign slice_base = int'(chunk_q) * RESTORE_W;
  assign cur_slice  = pending_q[slice_base +: RESTORE_W];

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    target_d    = target_q;
    tag_d       = tag_q;
    flush_cnt_d = flush_cnt_q;
    chunk_d     = chunk_q;

    case (state_q)
      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d = ST_RESTORE;
        end else begin
          flush_cnt_d = flush_cnt_q - FCW'(1);
        end
      end
      ST_RESTORE: begin
        // The chunk on the bus this cycle is consumed by the ready table, so drop it now.
        pending_d[slice_base +: RESTORE_W] = '0;
        if (chunk_q == LAST_CHUNK) begin
          state_d = ST_REDIRECT;
        end else begin
          chunk_d = chunk_q + CW'(1);
        end
      end
      ST_REDIRECT: begin
        if (bus.redirect_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
      end
    endcase

    // A new accept overrides whatever the sequence was doing, but merges into (never replaces)
    // the pending mask, after any slice clear above, so unsent ready bits survive the restart.
    if (accept) begin
      pending_d   = pending_d | bus.snapshot.reset_reg_rdy_table;
      target_d    = bus.mispredict_target;
      tag_d       = bus.snapshot.rob_tag;
      flush_cnt_d = FLUSH_INIT;
      chunk_d     = '0;
      state_d     = ST_FLUSH;
    end
  end

`ifdef RECOVERY_PERF_EN
  always_comb begin
    count_d  = count_q;
    cycles_d = cycles_q;
    if (accept && count_q != 16'hFFFF) begin
      count_d = count_q + 16'd1;
    end
    if (state_q != ST_IDLE && cycles_q != 16'hFFFF) begin
      cycles_d = cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      cycles_q <= '0;
    end else begin
      count_q  <= count_d;
      cycles_q <= cycles_d;
    end
  end

  assign bus.recover_count  = count_q;
  assign bus.recover_cycles = cycles_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      target_q    <= '0;
      tag_q       <= '0;
      flush_cnt_q <= '0;
      chunk_q     <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      target_q    <= target_d;
      tag_q       <= tag_d;
      flush_cnt_q <= flush_cnt_d;
      chunk_q     <= chunk_d;
    end
  end

  // Data outputs are gated by their state so the bus reads all-zero whenever a field is not live.
  assign bus.flush             = (state_q == ST_FLUSH);
  assign bus.stall_rename      = (state_q != ST_IDLE);
  assign bus.rdy_restore_valid = (state_q == ST_RESTORE);
  assign bus.rdy_restore_idx   = (state_q == ST_RESTORE) ? chunk_q : '0;
  assign bus.rdy_restore_mask  = (state_q == ST_RESTORE) ? cur_slice : '0;
  assign bus.redirect_valid    = (state_q == ST_REDIRECT);
  assign bus.redirect_pc       = (state_q == ST_REDIRECT) ? target_q : '0;
  assign bus.recover_rob_tag   = (state_q != ST_IDLE) ? tag_q : '0;

endmodule

// File: doc/recovery_ctrl.md
# recovery_ctrl

- Sequences branch-mispredict recovery downstream of the checkpoint unit.
- When a valid checkpoint snapshot arrives, it:
  - flushes the pipeline for a fixed number of cycles;
  - streams the snapshot's physical-register ready-restore mask to the ready table in fixed-width chunks;
  - redirects fetch to the corrected PC over a valid/ready handshake.
- Rename is stalled from acceptance until the redirect handshake completes.

## Interface
Parameters:
- NUM_PREG, 128, physical registers; must equal width of snapshot ready-restore field.
- RESTORE_W, 32, mask bits emitted per restore cycle; NUM_PREG must be a multiple.
- FLUSH_CYCLES, 2, cycles flush is held high (>=1).

Ports (CW = $clog2(NUM_PREG/RESTORE_W), min 1):
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low (asserted at 0).
- checkpoint_valid  in  1  snapshot valid this cycle.
- snapshot  in  checkpoint  snapshot fields used:
  - valid, pc, rob_tag;
  - reset_reg_rdy_table[NUM_PREG-1:0].
- mispredict_target  in  32  correct fetch PC, qualified by checkpoint_valid.
- redirect_ready  in  1  fetch accepts redirect.
- flush  out  1  kill all speculative in-flight instructions.
- stall_rename  out  1  high whenever state != IDLE.
- rdy_restore_valid  out  1  restore chunk valid.
- rdy_restore_idx  out  CW  chunk index; covers bits [idx*RESTORE_W +: RESTORE_W].
- rdy_restore_mask  out  RESTORE_W  bits to set ready.
- redirect_valid  out  1  redirect request.
- redirect_pc  out  32  redirect target.
- recover_rob_tag  out  5  rob_tag of the event in progress.

## Operation
- States: IDLE, FLUSH, RESTORE, REDIRECT.
- Registered state:
  - pending mask, NUM_PREG bits;
  - target PC;
  - rob_tag;
  - flush counter;
  - chunk counter.
- Accept condition: checkpoint_valid && snapshot.valid, in any state.
- On accept:
  - pending_mask <= pending_mask | snapshot.reset_reg_rdy_table;
  - target <= mispredict_target;
  - tag <= snapshot.rob_tag;
  - flush counter <= FLUSH_CYCLES-1, chunk counter <= 0;
  - state <= FLUSH.
- An accept in any state restarts the sequence; no pending mask bit is ever dropped.
- FLUSH:
  - flush=1.
  - Counter decrements each cycle.
  - At 0 -> RESTORE.
- RESTORE:
  - rdy_restore_valid=1, idx = chunk counter, mask = pending_mask slice at that index.
  - Every chunk is emitted, including all-zero chunks.
  - The emitted slice is cleared in pending_mask at the same edge.
  - After chunk NUM_PREG/RESTORE_W-1 -> REDIRECT.
- REDIRECT:
  - redirect_valid=1, redirect_pc = target.
  - On redirect_ready -> IDLE.
  - redirect_pc is held stable while waiting.
- flush, rdy_restore_valid and redirect_valid are mutually exclusive.
- Outputs are decoded from registered state only; no combinational path from any input to any output.
- checkpoint_valid without snapshot.valid is ignored.

## Timing
- Reset values:
  - state IDLE;
  - all outputs 0; redirect_pc 0, recover_rob_tag 0;
  - pending mask, counters and target 0.
- Accept sampled at edge ending cycle T. Then:
  - flush is high for cycles T+1 .. T+FLUSH_CYCLES;
  - restore chunks are emitted at cycles T+FLUSH_CYCLES+1 .. T+FLUSH_CYCLES+NUM_PREG/RESTORE_W;
  - redirect_valid rises on the following cycle.
- Minimum accept-to-idle latency: FLUSH_CYCLES + NUM_PREG/RESTORE_W + 1 cycles, with redirect_ready already high.
- stall_rename rises at T+1 and falls the cycle after the redirect handshake.
- Accept in the same cycle as a redirect handshake: the accept wins; the handshake still completes (that redirect is consumed), and the next state is FLUSH.
- Accept during RESTORE: the chunk emitted that cycle is still cleared, then the new mask is ORed in, and the walk restarts at chunk 0.
- Reset asserted mid-operation: asynchronous return to IDLE, all outputs 0 immediately, pending mask discarded.

## Configuration
- RECOVERY_PERF_EN defined adds two outputs:
  - recover_count, 16 bits: increments on every accept;
  - recover_cycles, 16 bits: increments each cycle state != IDLE.
  - Both saturate at 0xFFFF and reset to 0.
- Not defined: these ports and counters are absent; all other behaviour is identical.

## Test plan
All scenarios use default parameters.
- Basic recovery:
  - Stimulus: accept at T; bits 5 and 70 set in the table; target 0x00001040; tag 3; redirect_ready=1.
  - Response:
    - flush high T+1..T+2;
    - restore idx 0..3 at T+3..T+6: idx0 mask 0x00000020, idx2 mask 0x00000040, idx1 and idx3 zero;
    - redirect_valid with redirect_pc 0x00001040 at T+7;
    - IDLE and stall_rename=0 at T+8.
- Backpressure: same as basic recovery, redirect_ready held 0 for 5 cycles -> redirect_valid and redirect_pc 0x00001040 stable for 6 cycles; IDLE one cycle after ready.
- Nested mispredict:
  - Stimulus: second accept at T+4 with bit 100 set and target 0x2000.
  - Response: flush restarts at T+5; restore walk restarts at idx 0; bit 70 (chunk 2, unsent) and bit 100 both emitted; redirect to 0x2000 only.
- Ignored input: checkpoint_valid=1 with snapshot.valid=0 -> state stays IDLE, all outputs 0.
- Async reset: reset driven to 0 during RESTORE -> outputs 0 before the next clock edge; after release, a new accept produces no stale mask bits.
- Perf counters (RECOVERY_PERF_EN defined): basic recovery -> recover_count=1, recover_cycles=7.
